// File: rtl/complex_proj_accum_if.sv
// Bus bundle for the projection accumulator: gated pdQp sample streams plus
// the controller phase in, saturated projection results and status out.
interface complex_proj_accum_if #(
  parameter int W = 34
);
  // i_d0/i_d1/i_d2/i_cntr are sampled on every rising edge; i_cntr alone says
  // whether the samples are meaningful. o_valid is a one-cycle pulse with no
  // ready: the consumer must take o_re/o_im/o_en/o_sat in that cycle.
  logic signed [W-1:0] i_d0;
  logic signed [W-1:0] i_d1;
  logic signed [W-1:0] i_d2;
  logic        [2:0]   i_cntr;
  logic signed [W-1:0] o_re;
  logic signed [W-1:0] o_im;
  logic signed [W-1:0] o_en;
  logic                o_valid;
  logic                o_sat;
  logic                o_seq_err;
  logic                o_busy;

  modport master (
    output i_d0, i_d1, i_d2, i_cntr,
    input  o_re, o_im, o_en, o_valid, o_sat, o_seq_err, o_busy
  );

  modport slave (
    input  i_d0, i_d1, i_d2, i_cntr,
    output o_re, o_im, o_en, o_valid, o_sat, o_seq_err, o_busy
  );
endinterface

// File: rtl/complex_proj_accum.sv
// Accumulates d0*d2, d1*d2 and d2*d2 over the six controller phases and
// publishes the saturated pdQp sums with a single-cycle valid pulse.
module complex_proj_accum #(
  parameter int pd    = 12,
  parameter int p     = 22,
  parameter int GUARD = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  complex_proj_accum_if.slave   bus,
  output logic [1:0]            dbg_state_o
);
  localparam int W    = pd + p;
  localparam int PW   = 2 * W;
  localparam int ACCW = 2 * pd + p + GUARD;
  localparam logic signed [ACCW-1:0] ACC_MAX = {{(ACCW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {{(ACCW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e                 state_q;
  logic [2:0]             cntr;
  logic [2:0]             exp_q, exp_d;
  logic                   accept, viol;
  logic signed [ACCW-1:0] p0_d, p1_d, p2_d;
  logic signed [ACCW-1:0] p0_q, p1_q, p2_q;
  logic                   pv_q, pf_q, pl_q;
  logic signed [ACCW-1:0] acc0_q, acc1_q, acc2_q;
  logic [W:0]             clip0, clip1, clip2;
  logic signed [W-1:0]    res0_q, res1_q, res2_q;
  logic signed [W-1:0]    re_q, im_q, en_q;
  logic                   res_sat_q, fin_q, valid_q, sat_q, seq_err_q;

  // Full-precision product rescaled to pdQp; the 2*pd+p significant bits
  // always fit the guarded accumulator width.
  function automatic logic signed [ACCW-1:0] mul_q(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
    return ACCW'((PW'(a) * PW'(b)) >>> p);
  endfunction

  // Returns {clipped, value} with the value limited to the W-bit signed range.
  function automatic logic [W:0] clip(input logic signed [ACCW-1:0] a);
    if (a > ACC_MAX) return {1'b1, 1'b0, {(W-1){1'b1}}};
    if (a < ACC_MIN) return {1'b1, 1'b1, {(W-1){1'b0}}};
    return {1'b0, a[W-1:0]};
  endfunction

  assign cntr = bus.i_cntr;
  assign p0_d = mul_q(bus.i_d0, bus.i_d2);
  assign p1_d = mul_q(bus.i_d1, bus.i_d2);
  assign p2_d = mul_q(bus.i_d2, bus.i_d2);

  // Phase 1 always restarts a batch; any other non-zero code must match the
  // expected phase, otherwise the batch is abandoned.
  always_comb begin
    accept = (cntr == 3'd1) || ((cntr != 3'd0) && (cntr == exp_q));
    viol   = (cntr != 3'd0) && !accept;
    exp_d  = exp_q;
    if (accept) begin
      exp_d = (cntr == 3'd6) ? 3'd1 : cntr + 3'd1;
    end else if (viol) begin
      exp_d = 3'd1;
    end
  end

  assign clip0 = clip(acc0_q);
  assign clip1 = clip(acc1_q);
  assign clip2 = clip(acc2_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q      <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      pv_q      <= 1'b0;
      pf_q      <= 1'b0;
      pl_q      <= 1'b0;
      exp_q     <= 3'd1;
      seq_err_q <= 1'b0;
    end else begin
      p0_q      <= p0_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      pv_q      <= accept;
      pf_q      <= accept && (cntr == 3'd1);
      pl_q      <= accept && (cntr == 3'd6);
      exp_q     <= exp_d;
      seq_err_q <= seq_err_q | viol;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc0_q    <= '0;
      acc1_q    <= '0;
      acc2_q    <= '0;
      res0_q    <= '0;
      res1_q    <= '0;
      res2_q    <= '0;
      res_sat_q <= 1'b0;
      fin_q     <= 1'b0;
      valid_q   <= 1'b0;
      re_q      <= '0;
      im_q      <= '0;
      en_q      <= '0;
      sat_q     <= 1'b0;
    end else begin
      if (pv_q) begin
        acc0_q <= pf_q ? p0_q : acc0_q + p0_q;
        acc1_q <= pf_q ? p1_q : acc1_q + p1_q;
        acc2_q <= pf_q ? p2_q : acc2_q + p2_q;
      end
      fin_q   <= 1'b0;
      valid_q <= fin_q;
      if (fin_q) begin
        re_q  <= res0_q;
        im_q  <= res1_q;
        en_q  <= res2_q;
        sat_q <= res_sat_q;
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= ACCUM;
        end
        ACCUM: begin
          // A completed batch wins over a violation arriving behind it.
          if (pv_q && pl_q) state_q <= FINISH;
          else if (viol)    state_q <= IDLE;
        end
        FINISH: begin
          res0_q    <= clip0[W-1:0];
          res1_q    <= clip1[W-1:0];
          res2_q    <= clip2[W-1:0];
          res_sat_q <= clip0[W] | clip1[W] | clip2[W];
          fin_q     <= 1'b1;
          // The next batch may already be running in the pipeline.
          state_q   <= (accept || ((exp_q != 3'd1) && !viol)) ? ACCUM : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_re      = re_q;
  assign bus.o_im      = im_q;
  assign bus.o_en      = en_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_sat     = sat_q;
  assign bus.o_seq_err = seq_err_q;
  assign bus.o_busy    = (state_q != IDLE);
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_complex_proj_accum.sv
// Bench for complex_proj_accum: directed batches plus random phase traffic,
// checked every cycle against a batch-level model of the projection sums.
module tb_complex_proj_accum;
  localparam int W = 34;
  localparam logic [W-1:0] ONE   = 34'h000400000;
  localparam logic [W-1:0] TWO   = 34'h000800000;
  localparam logic [W-1:0] HALFN = 34'h3FFE00000;
  localparam logic [W-1:0] F40   = 34'h00A000000;
  localparam logic [W-1:0] N40   = 34'h3F6000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  complex_proj_accum_if #(.W(W)) bus ();
  logic [1:0] dbg_state;

  complex_proj_accum #(.pd(12), .p(22), .GUARD(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic signed [69:0] pm(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [69:0] x, y;
    x = 70'($signed(a));
    y = 70'($signed(b));
    return (x * y) >>> 22;
  endfunction

  function automatic logic [W:0] sat_m(input logic signed [69:0] v);
    if (v > 70'sd8589934591)  return {1'b1, 34'h1FFFFFFFF};
    if (v < -70'sd8589934592) return {1'b1, 34'h200000000};
    return {1'b0, v[W-1:0]};
  endfunction

  int                 cyc = 0;
  int                 exp_ph = 1;
  logic signed [69:0] s_re = '0, s_im = '0, s_en = '0;
  bit                 m_err = 0, a6_cur = 0, a6_prev = 0;
  logic [3*W:0]       exp_q[$];
  int                 due_q[$];
  logic [W-1:0]       h_re = '0, h_im = '0, h_en = '0;
  bit                 h_sat = 0;
  int                 n_valid = 0;
  int                 vcyc_q[$];
  int                 ph6_cyc = 0;

  // Scoreboard: update the model from the inputs sampled at this edge, then
  // compare every DUT output shortly after the edge.
  always @(posedge clk) begin
    logic [2:0]   c;
    logic [W:0]   r0, r1, r2;
    logic [3*W:0] e;
    bit           exp_v, busy_m;
    cyc++;
    c = bus.i_cntr;
    if (rst) begin
      exp_ph = 1; m_err = 0; a6_cur = 0; a6_prev = 0;
      exp_q.delete(); due_q.delete();
      h_re = '0; h_im = '0; h_en = '0; h_sat = 0;
    end else begin
      a6_prev = a6_cur;
      a6_cur  = 0;
      if (c == 3'd1) begin
        s_re = pm(bus.i_d0, bus.i_d2);
        s_im = pm(bus.i_d1, bus.i_d2);
        s_en = pm(bus.i_d2, bus.i_d2);
        exp_ph = 2;
      end else if (c != 3'd0 && int'(c) == exp_ph) begin
        s_re += pm(bus.i_d0, bus.i_d2);
        s_im += pm(bus.i_d1, bus.i_d2);
        s_en += pm(bus.i_d2, bus.i_d2);
        if (c == 3'd6) begin
          r0 = sat_m(s_re); r1 = sat_m(s_im); r2 = sat_m(s_en);
          exp_q.push_back({r0[W] | r1[W] | r2[W], r0[W-1:0], r1[W-1:0], r2[W-1:0]});
          due_q.push_back(cyc + 3);
          exp_ph = 1;
          a6_cur = 1;
        end else begin
          exp_ph = int'(c) + 1;
        end
      end else if (c != 3'd0) begin
        m_err  = 1;
        exp_ph = 1;
      end
    end
    exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
    if (exp_v) begin
      void'(due_q.pop_front());
      e = exp_q.pop_front();
      h_sat = e[3*W];
      h_re  = e[3*W-1:2*W];
      h_im  = e[2*W-1:W];
      h_en  = e[W-1:0];
    end
    busy_m = !rst && ((exp_ph != 1) || a6_cur || a6_prev);
    #1;
    if (bus.o_valid) begin
      n_valid++;
      vcyc_q.push_back(cyc);
    end
    check("valid",   W'(bus.o_valid),   W'(exp_v));
    check("busy",    W'(bus.o_busy),    W'(busy_m));
    check("seq_err", W'(bus.o_seq_err), W'(m_err));
    check("re",      bus.o_re,          h_re);
    check("im",      bus.o_im,          h_im);
    check("en",      bus.o_en,          h_en);
    check("sat",     W'(bus.o_sat),     W'(h_sat));
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] w);
    @(negedge clk);
    bus.i_cntr = c;
    bus.i_d0   = a;
    bus.i_d1   = b;
    bus.i_d2   = w;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(3'd0, '0, '0, '0);
  endtask

  task automatic batch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] w,
                       input int gap_at, input int gap_len);
    for (int ph = 1; ph <= 6; ph++) begin
      drive(3'(ph), a, b, w);
      if (ph == 6) ph6_cyc = cyc + 1;
      if (ph == gap_at) idle(gap_len);
    end
  endtask

  function automatic logic [W-1:0] rnd(input bit full);
    logic signed [25:0] t;
    if (full) return {2'($urandom_range(0, 3)), 32'($urandom())};
    t = 26'($urandom());
    return {{8{t[25]}}, t};
  endfunction

  task automatic check_single(input string tag);
    check({tag, "_re"}, bus.o_re,  34'h003000000);
    check({tag, "_im"}, bus.o_im,  34'h3FE800000);
    check({tag, "_en"}, bus.o_en,  34'h006000000);
    check({tag, "_sat"}, W'(bus.o_sat), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nv0, vs0, last;
    rst = 1'b1;
    bus.i_cntr = '0; bus.i_d0 = '0; bus.i_d1 = '0; bus.i_d2 = '0;
    repeat (3) @(negedge clk);
    check("rst_re",    bus.o_re, '0);
    check("rst_valid", W'(bus.o_valid), '0);
    check("rst_busy",  W'(bus.o_busy), '0);
    check("rst_err",   W'(bus.o_seq_err), '0);
    rst = 1'b0;
    idle(2);

    // single batch: value, pulse count and latency
    nv0 = n_valid;
    batch(ONE, HALFN, TWO, 0, 0);
    idle(8);
    check_single("single");
    check("single_pulses", W'(n_valid - nv0), W'(1));
    last = (vcyc_q.size() > 0) ? vcyc_q[vcyc_q.size()-1] : -100;
    check("single_latency", W'(last - ph6_cyc), W'(3));

    // saturation, both directions
    batch(F40, '0, F40, 0, 0);
    idle(8);
    check("satp_re",  bus.o_re, 34'h1FFFFFFFF);
    check("satp_im",  bus.o_im, '0);
    check("satp_en",  bus.o_en, 34'h1FFFFFFFF);
    check("satp_sat", W'(bus.o_sat), W'(1));
    batch(N40, '0, F40, 0, 0);
    idle(8);
    check("satn_re",  bus.o_re, 34'h200000000);
    check("satn_en",  bus.o_en, 34'h1FFFFFFFF);
    check("satn_sat", W'(bus.o_sat), W'(1));

    // sequence error 1,2,4 then a clean batch
    nv0 = n_valid;
    drive(3'd1, ONE, ONE, ONE);
    drive(3'd2, ONE, ONE, ONE);
    drive(3'd4, ONE, ONE, ONE);
    idle(6);
    check("seq_flag",   W'(bus.o_seq_err), W'(1));
    check("seq_busy",   W'(bus.o_busy), '0);
    check("seq_state",  W'(dbg_state), '0);
    check("seq_pulses", W'(n_valid - nv0), '0);
    batch(ONE, HALFN, TWO, 0, 0);
    idle(8);
    check_single("after_seq");
    check("seq_sticky", W'(bus.o_seq_err), W'(1));

    // reset in the middle of a batch
    drive(3'd1, F40, F40, F40);
    drive(3'd2, F40, F40, F40);
    @(negedge clk);
    rst = 1'b1;
    bus.i_cntr = 3'd3;
    @(negedge clk);
    check("mrst_re",  bus.o_re, '0);
    check("mrst_en",  bus.o_en, '0);
    check("mrst_sat", W'(bus.o_sat), '0);
    check("mrst_err", W'(bus.o_seq_err), '0);
    check("mrst_busy", W'(bus.o_busy), '0);
    rst = 1'b0;
    bus.i_cntr = 3'd0;
    idle(2);
    batch(ONE, HALFN, TWO, 0, 0);
    idle(8);
    check_single("after_mrst");

    // back-to-back batches
    nv0 = n_valid;
    vs0 = vcyc_q.size();
    batch(ONE, HALFN, TWO, 0, 0);
    batch(ONE, HALFN, ONE, 0, 0);
    idle(8);
    check("b2b_pulses", W'(n_valid - nv0), W'(2));
    last = (vcyc_q.size() >= vs0 + 2) ? vcyc_q[vs0+1] - vcyc_q[vs0] : -1;
    check("b2b_spacing", W'(last), W'(6));
    check("b2b_re", bus.o_re, 34'h001800000);
    check("b2b_im", bus.o_im, 34'h3FF400000);
    check("b2b_en", bus.o_en, 34'h001800000);

    // idle gap between phases 3 and 4
    batch(ONE, HALFN, TWO, 3, 4);
    idle(8);
    check_single("gap");

    // random traffic
    for (int it = 0; it < 250; it++) begin
      int  k;
      bit  full;
      k    = $urandom_range(0, 19);
      full = ($urandom_range(0, 3) == 0);
      if (k == 0) begin
        @(negedge clk);
        rst = 1'b1;
        bus.i_cntr = 3'($urandom_range(0, 7));
        @(negedge clk);
        rst = 1'b0;
        bus.i_cntr = 3'd0;
      end else if (k <= 3) begin
        repeat ($urandom_range(1, 4))
          drive(3'($urandom_range(0, 7)), rnd(full), rnd(full), rnd(full));
      end else begin
        int gap_at, gap_len;
        gap_at  = $urandom_range(0, 6);
        gap_len = $urandom_range(0, 3);
        for (int ph = 1; ph <= 6; ph++) begin
          drive(3'(ph), rnd(full), rnd(full), rnd(full));
          if (ph == gap_at) idle(gap_len);
        end
        idle($urandom_range(0, 3));
      end
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end
endmodule
